// File: rtl/sio_pkg.sv
// Shared constants for the SIO baud-rate controller: register map, bit positions
// and the reset divisor.
package sio_pkg;

  localparam int SIO_DIV_W   = 12;
  localparam int DEFAULT_DIV = 651;

  localparam logic [1:0] SIO_BAUD_DIV_LO = 2'd0;
  localparam logic [1:0] SIO_BAUD_DIV_HI = 2'd1;
  localparam logic [1:0] SIO_BAUD_CTRL   = 2'd2;
  localparam logic [1:0] SIO_BAUD_STAT   = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int STAT_PEND_BIT  = 0;
  localparam int STAT_EN_BIT    = 1;
  localparam int STAT_MATCH_BIT = 2;

endpackage

// File: rtl/sio_baud_ctrl_if.sv
// Z80 I/O-side register bus of the baud controller.
interface sio_baud_ctrl_if;

  logic       cs;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  modport master (output cs, wr, addr, wr_data, input rd_data);
  modport slave  (input cs, wr, addr, wr_data, output rd_data);

endinterface

// File: rtl/sio_tick_gen.sv
// Divide counter with 0/1 clamp, 16x sub-counter and sio_clk toggle.
// tc is the combinational terminal-count strobe the register file commits on.
module sio_tick_gen #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tc,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             sio_clk
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] last;
  logic [3:0]       sub;

  // Divisors below 2 would tick every cycle; hold them at 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  assign eff_div = clamp_div(div);
  assign last    = eff_div - DIV_W'(1);
  assign tc      = en & (count == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      sub     <= '0;
      sio_clk <= 1'b0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
      if (!en) begin
        count   <= '0;
        sub     <= '0;
        sio_clk <= 1'b0;
      end else if (tc) begin
        count   <= '0;
        rx_tick <= 1'b1;
        tx_tick <= (sub == 4'hF);
        sub     <= sub + 4'd1;
        sio_clk <= ~sio_clk;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sio_baud_ctrl.sv
// Programmable SIO baud-rate controller: CPU-visible divisor shadow, staged commit
// into the active divisor at period boundaries, and the tick generator.
module sio_baud_ctrl #(
  parameter int DIV_W       = sio_pkg::SIO_DIV_W,
  parameter int DEFAULT_DIV = sio_pkg::DEFAULT_DIV
) (
  input  logic           clk,
  input  logic           rst,
  sio_baud_ctrl_if.slave bus,
  output logic           rx_tick,
  output logic           tx_tick,
  output logic           sio_clk
);

  import sio_pkg::*;

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] active_div;
  logic             en;
  logic             pending;
  logic             tc;
  logic             wr_en;
  logic             commit;

  assign wr_en  = bus.cs & bus.wr;
  // Idle commits immediately; running commits only on the period boundary.
  assign commit = pending & (~en | tc);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= DIV_W'(DEFAULT_DIV);
      active_div <= DIV_W'(DEFAULT_DIV);
      en         <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (commit) begin
        active_div <= shadow;
        pending    <= 1'b0;
      end
      // A HI write coinciding with a commit keeps pending for the new value.
      if (wr_en) begin
        case (bus.addr)
          SIO_BAUD_DIV_LO: shadow[7:0] <= bus.wr_data;
          SIO_BAUD_DIV_HI: begin
            shadow  <= DIV_W'({bus.wr_data, shadow[7:0]});
            pending <= 1'b1;
          end
          SIO_BAUD_CTRL:   en <= bus.wr_data[CTRL_EN_BIT];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      SIO_BAUD_DIV_LO: bus.rd_data = shadow[7:0];
      SIO_BAUD_DIV_HI: bus.rd_data = 8'(shadow >> 8);
      SIO_BAUD_CTRL:   bus.rd_data[CTRL_EN_BIT] = en;
      SIO_BAUD_STAT: begin
        bus.rd_data[STAT_PEND_BIT]  = pending;
        bus.rd_data[STAT_EN_BIT]    = en;
        bus.rd_data[STAT_MATCH_BIT] = (active_div == shadow);
      end
      default: ;
    endcase
  end

  sio_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (active_div),
    .tc      (tc),
    .rx_tick (rx_tick),
    .tx_tick (tx_tick),
    .sio_clk (sio_clk)
  );

endmodule

// File: tb/tb_sio_baud_ctrl.sv
// Bench for sio_baud_ctrl: register vector table plus tick-timing sequences,
// with expected ticks and read data held in scoreboard queues.
module tb_sio_baud_ctrl;

  localparam int DEF = 651;

  logic clk;
  logic rst;
  logic rx_tick;
  logic tx_tick;
  logic sio_clk;

  sio_baud_ctrl_if bus();

  sio_baud_ctrl #(
    .DIV_W       (12),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rx_tick (rx_tick),
    .tx_tick (tx_tick),
    .sio_clk (sio_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int tx;
    int sclk;
  } tick_t;

  typedef struct {
    logic       cs;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  tick_t      tick_q[$];
  logic [7:0] rd_q[$];
  vec_t       vt[19];
  int         cyc;
  int         n_vec;
  int         n_fail;
  int         n0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int k);
    tick_t t;
    t.cyc  = c;
    t.tx   = (k % 16 == 0) ? 1 : 0;
    t.sclk = k % 2;
    tick_q.push_back(t);
  endtask

  // Every clock advance goes through here so tick outputs are checked each cycle.
  task automatic step();
    tick_t t;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_tick) begin
      if (tick_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_tick=1, expected 0 at cycle %0d", cyc);
      end else begin
        t = tick_q.pop_front();
        chk("rx_time", cyc, t.cyc);
        chk("tx_tick", int'(tx_tick), t.tx);
        chk("sio_clk_at_tick", int'(sio_clk), t.sclk);
      end
    end else if (tx_tick) begin
      n_vec++;
      n_fail++;
      $display("FAIL tx_without_rx: got tx_tick=1, expected 0 at cycle %0d", cyc);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    step();
    bus.cs = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    bus.addr = a;
    rd_q.push_back(exp);
    #1;
    chk(name, int'(bus.rd_data), int'(rd_q.pop_front()));
  endtask

  task automatic drained(input string name);
    chk(name, tick_q.size(), 0);
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_fail = 0;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wr_data = 8'h00;
    rst = 1'b1;

    //            cs    wr    addr   data   chk   exp
    vt[0]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h8B};
    vt[2]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h02};
    vt[3]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h04};
    vt[4]  = '{1'b1, 1'b1, 2'd0, 8'h34, 1'b0, 8'h00};
    vt[5]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h34};
    vt[6]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h34};
    vt[8]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00};
    vt[9]  = '{1'b1, 1'b1, 2'd1, 8'hF1, 1'b0, 8'h00};
    vt[10] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h01};
    vt[11] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h04};
    vt[12] = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h01};
    vt[13] = '{1'b1, 1'b1, 2'd2, 8'hFE, 1'b0, 8'h00};
    vt[14] = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00};
    vt[15] = '{1'b1, 1'b1, 2'd2, 8'h01, 1'b0, 8'h00};
    vt[16] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h06};
    vt[17] = '{1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 8'h00};
    vt[18] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h04};

    step(); step();
    rst = 1'b0;
    chk("rst_sio_clk", int'(sio_clk), 0);

    for (int i = 0; i < 19; i++) begin
      bus.cs = vt[i].cs; bus.wr = vt[i].wr; bus.addr = vt[i].addr; bus.wr_data = vt[i].data;
      if (vt[i].chk) begin
        rd_q.push_back(vt[i].exp);
        #1;
        chk($sformatf("vec%0d", i), int'(bus.rd_data), int'(rd_q.pop_front()));
      end
      step();
      bus.cs = 1'b0; bus.wr = 1'b0;
    end

    // Default divisor: rx every 651, tx every 10416, sio_clk period 1302.
    rst = 1'b1; step(); rst = 1'b0;
    rd_chk("t1_ctrl_rst", 2'd2, 8'h00);
    wr(2'd2, 8'h01);
    n0 = cyc;
    for (int k = 1; k <= 32; k++) push_tick(n0 + DEF * k, k);
    run_to(n0 + DEF * 32 + 3);
    drained("t1_drained");
    wr(2'd2, 8'h00);

    // Divisor change to 10 mid-period, then disable/re-enable resets sub and sio_clk.
    wr(2'd2, 8'h01);
    n0 = cyc;
    push_tick(n0 + DEF, 1);
    for (int k = 2; k <= 19; k++) push_tick(n0 + DEF + 10 * (k - 1), k);
    run_to(n0 + 299);
    wr(2'd0, 8'h0A);
    wr(2'd1, 8'h00);
    rd_chk("t2_stat_pend", 2'd3, 8'h03);
    run_to(n0 + DEF - 1);
    rd_chk("t2_stat_pend_end", 2'd3, 8'h03);
    step();
    rd_chk("t2_stat_commit", 2'd3, 8'h06);
    run_to(n0 + DEF + 180);
    wr(2'd2, 8'h00);
    step();
    chk("t2_dis_sio_clk", int'(sio_clk), 0);
    rd_chk("t2_stat_idle", 2'd3, 8'h04);
    wr(2'd2, 8'h01);
    n0 = cyc;
    for (int k = 1; k <= 16; k++) push_tick(n0 + 10 * k, k);
    run_to(n0 + 165);
    wr(2'd2, 8'h00);
    drained("t2_drained");

    // Divisors 0 and 1 both act as 2.
    for (int d = 0; d <= 1; d++) begin
      wr(2'd0, 8'(d));
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h01);
      n0 = cyc;
      for (int k = 1; k <= 8; k++) push_tick(n0 + 2 * k, k);
      run_to(n0 + 16);
      wr(2'd2, 8'h00);
      step();
      rd_chk($sformatf("t3_lo_d%0d", d), 2'd0, 8'(d));
      rd_chk($sformatf("t3_stat_d%0d", d), 2'd3, 8'h04);
    end
    drained("t3_drained");

    // HI write on the terminal-count edge: old shadow (12) commits, 268 follows.
    wr(2'd0, 8'h14);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h01);
    n0 = cyc;
    push_tick(n0 + 20, 1);
    push_tick(n0 + 40, 2);
    push_tick(n0 + 52, 3);
    push_tick(n0 + 320, 4);
    run_to(n0 + 25);
    wr(2'd0, 8'h0C);
    wr(2'd1, 8'h00);
    run_to(n0 + 39);
    wr(2'd1, 8'h01);
    rd_chk("t4_stat_tc", 2'd3, 8'h03);
    run_to(n0 + 51);
    rd_chk("t4_stat_still", 2'd3, 8'h03);
    step();
    rd_chk("t4_stat_commit", 2'd3, 8'h06);
    rd_chk("t4_hi", 2'd1, 8'h01);
    run_to(n0 + 330);
    wr(2'd2, 8'h00);
    drained("t4_drained");

    // Reset asserted on what would be a tick edge mid-RUN.
    wr(2'd2, 8'h01);
    n0 = cyc;
    push_tick(n0 + 268, 1);
    run_to(n0 + 535);
    rst = 1'b1;
    step();
    chk("t6_rx", int'(rx_tick), 0);
    chk("t6_tx", int'(tx_tick), 0);
    chk("t6_sio_clk", int'(sio_clk), 0);
    rd_chk("t6_ctrl", 2'd2, 8'h00);
    rd_chk("t6_stat", 2'd3, 8'h04);
    rd_chk("t6_lo", 2'd0, 8'h8B);
    rd_chk("t6_hi", 2'd1, 8'h02);
    rst = 1'b0;
    run_to(n0 + 536 + 700);
    drained("t6_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
